ofdm_interleaver: RTL and testbench

Bit interleaver for the 802.11a transmit chain, directly downstream of `encoder`. It consumes the serial coded (and punctured) bit stream `data_out` from `encoder` and applies the two-step 802.11a block permutation over one OFDM symbol of N_CBPS bits. It emits the permuted bits serially to the mapper, one bit per clock. A ping-pong pair of symbol buffers lets input and output run concurrently with no back-pressure.

---
 rtl/ofdm_interleaver_pkg.sv | 48 ++++
 rtl/ofdm_interleaver_if.sv | 14 +
 rtl/ofdm_interleaver_addr.sv | 39 +++
 rtl/ofdm_interleaver.sv | 140 ++++++++++++++
 tb/tb_ofdm_interleaver.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_interleaver_pkg.sv
// Shared 802.11a constants: modulation codes, N_CBPS per modulation and N_CBPS/16.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package ofdm_interleaver_pkg;

    localparam int MAX_CBPS = 288;

    localparam logic [1:0] MOD_BPSK  = 2'd0;
    localparam logic [1:0] MOD_QPSK  = 2'd1;
    localparam logic [1:0] MOD_16QAM = 2'd2;
    localparam logic [1:0] MOD_64QAM = 2'd3;

    localparam logic [8:0] NCBPS_BPSK  = 9'd48;
    localparam logic [8:0] NCBPS_QPSK  = 9'd96;
    localparam logic [8:0] NCBPS_16QAM = 9'd192;
    localparam logic [8:0] NCBPS_64QAM = 9'd288;

    localparam logic [4:0] CDIV_BPSK  = 5'd3;
    localparam logic [4:0] CDIV_QPSK  = 5'd6;
    localparam logic [4:0] CDIV_16QAM = 5'd12;
    localparam logic [4:0] CDIV_64QAM = 5'd18;

    // Coded bits per OFDM symbol for a modulation code.
    function automatic logic [8:0] ncbps_of(input logic [1:0] m);
        case (m)
            MOD_BPSK:  return NCBPS_BPSK;
            MOD_QPSK:  return NCBPS_QPSK;
            MOD_16QAM: return NCBPS_16QAM;
            default:   return NCBPS_64QAM;
        endcase
    endfunction

    // N_CBPS/16, the column stride of the first permutation.
    function automatic logic [4:0] cdiv16_of(input logic [1:0] m);
        case (m)
            MOD_BPSK:  return CDIV_BPSK;
            MOD_QPSK:  return CDIV_QPSK;
            MOD_16QAM: return CDIV_16QAM;
            default:   return CDIV_64QAM;
        endcase
    endfunction

    // floor(x/3) as multiply-by-171 and shift by 9; exact for every x below 512.
    function automatic logic [8:0] div3(input logic [8:0] x);
        return 9'((18'(x) * 18'd171) >> 9);
    endfunction

endpackage

// File: rtl/ofdm_interleaver_if.sv
// Bit-serial stream bundle between encoder, interleaver and mapper.
// Latency: n/a (wires only).
// Backpressure: none; en and out_valid are pure qualifiers.
interface ofdm_interleaver_if;
    logic       en;
    logic [1:0] mod;
    logic       data_in;
    logic       data_out;
    logic       out_valid;
    logic       sym_start;

    modport master (output en, mod, data_in, input data_out, out_valid, sym_start);
    modport slave  (input en, mod, data_in, output data_out, out_valid, sym_start);
endinterface

// File: rtl/ofdm_interleaver_addr.sv
// Write address j for write position (c, r) under the two-step 802.11a permutation.
// Latency: combinational.
// Backpressure: n/a.
module ofdm_interleaver_addr
    import ofdm_interleaver_pkg::*;
(
    input  logic [3:0] c,
    input  logic [4:0] r,
    input  logic [1:0] mod,
    output logic [8:0] j
);

    logic [8:0] i;
    logic [8:0] q3;
    logic [8:0] cq;
    logic [1:0] ri;
    logic [1:0] rc;
    logic [2:0] d;

    // First permutation gives i; second rotates within groups of s bits, (i - c) mod s.
    always_comb begin
        i  = 9'(cdiv16_of(mod)) * 9'(c) + 9'(r);
        q3 = div3(i);
        ri = 2'(i - 9'd3 * q3);
        cq = div3(9'(c));
        rc = 2'(9'(c) - 9'd3 * cq);
        d  = 3'(ri) + 3'd3 - 3'(rc);
        if (d >= 3'd3) begin
            d = d - 3'd3;
        end
        j = i;
        case (mod)
            MOD_16QAM: j = {i[8:1], i[0] ^ c[0]};
            MOD_64QAM: j = 9'd3 * q3 + 9'(d);
            default:   j = i;
        endcase
    end

endmodule

// File: rtl/ofdm_interleaver.sv
// 802.11a bit interleaver with ping-pong symbol banks; permutes on write, reads sequentially.
// Latency: first output bit one cycle after the last bit of a symbol is accepted.
// Backpressure: none; en pauses writing only, reads stream continuously once a bank is full.
module ofdm_interleaver
    import ofdm_interleaver_pkg::*;
(
    input  logic               Clk,
    input  logic               reset,
    ofdm_interleaver_if.slave  bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    // Write side
    logic [8:0]          k;
    logic [3:0]          c;
    logic [4:0]          r;
    logic                wr_bank;
    logic [1:0]          bank_mod [2];
    logic [1:0]          full;
    logic [MAX_CBPS-1:0] mem [2];
    logic [1:0]          mod_w;
    logic [8:0]          ncbps_w;
    logic [8:0]          j;
    logic                wr_last;

    // Read side
    logic [0:0]          state;
    logic                rd_bank;
    logic [8:0]          n;
    logic [8:0]          rd_ncbps;
    logic                rd_last;
    logic                nb;
    logic                start;

    // Bit 0 of a symbol uses the live mod (it is latched on that same edge); later bits use the latch.
    always_comb begin
        mod_w   = (k == 9'd0) ? bus.mod : bank_mod[wr_bank];
        ncbps_w = ncbps_of(mod_w);
        wr_last = (k == ncbps_w - 9'd1);
    end

    ofdm_interleaver_addr u_addr (
        .c   (c),
        .r   (r),
        .mod (mod_w),
        .j   (j)
    );

    // Write counters, bank pointer and per-bank modulation descriptor.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            k           <= 9'd0;
            c           <= 4'd0;
            r           <= 5'd0;
            wr_bank     <= 1'b0;
            bank_mod[0] <= MOD_BPSK;
            bank_mod[1] <= MOD_BPSK;
        end else if (bus.en) begin
            if (k == 9'd0) begin
                bank_mod[wr_bank] <= bus.mod;
            end
            if (wr_last) begin
                k       <= 9'd0;
                c       <= 4'd0;
                r       <= 5'd0;
                wr_bank <= ~wr_bank;
            end else begin
                k <= k + 9'd1;
                c <= c + 4'd1;
                if (c == 4'd15) begin
                    r <= r + 5'd1;
                end
            end
        end
    end

    // Bank storage; contents survive reset, only the pointers and flags are cleared.
    always_ff @(posedge Clk) begin
        if (bus.en) begin
            mem[wr_bank][j] <= bus.data_in;
        end
    end

    // rd_last fires the cycle after bit N_CBPS-1 went out, so a waiting bank follows with no gap.
    always_comb begin
        rd_last = (state == READ) && (n == rd_ncbps);
        nb      = rd_last ? ~rd_bank : rd_bank;
        start   = ((state == IDLE) || rd_last) && full[nb];
    end

    // Full flags: cleared when the reader claims a bank, set when the writer completes one.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            if (start) begin
                full[nb] <= 1'b0;
            end
            if (bus.en && wr_last) begin
                full[wr_bank] <= 1'b1;
            end
        end
    end

    // Read FSM: bit 0 is emitted on the claiming edge, then one bit per cycle in address order.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rd_bank       <= 1'b0;
            n             <= 9'd0;
            rd_ncbps      <= 9'd0;
            bus.data_out  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.sym_start <= 1'b0;
        end else if (start) begin
            state         <= READ;
            rd_bank       <= nb;
            rd_ncbps      <= ncbps_of(bank_mod[nb]);
            n             <= 9'd1;
            bus.data_out  <= mem[nb][0];
            bus.out_valid <= 1'b1;
            bus.sym_start <= 1'b1;
        end else if ((state == READ) && !rd_last) begin
            n             <= n + 9'd1;
            bus.data_out  <= mem[rd_bank][n];
            bus.out_valid <= 1'b1;
            bus.sym_start <= 1'b0;
        end else begin
            state         <= IDLE;
            rd_bank       <= nb;
            n             <= 9'd0;
            bus.data_out  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.sym_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ofdm_interleaver.sv
// Directed bench for ofdm_interleaver: single-bit impulses, streaming, gapped writes, reset mid-read.
// Latency: n/a.
// Backpressure: n/a.
module tb_ofdm_interleaver;

    logic Clk = 1'b0;
    logic reset;

    always #5 Clk = ~Clk;

    ofdm_interleaver_if bus ();

    ofdm_interleaver dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic stim [384];
    logic gold [384];

    task automatic check_eq(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ncbps_ref(input int m);
        return (m == 0) ? 48 : (m == 1) ? 96 : (m == 2) ? 192 : 288;
    endfunction

    // Reference permutation, straight from the textbook formula.
    function automatic int ref_j(input int m, input int k);
        int nc, s, c, r, i;
        nc = ncbps_ref(m);
        s  = (m <= 1) ? 1 : (m == 2) ? 2 : 3;
        c  = k % 16;
        r  = k / 16;
        i  = (nc / 16) * c + r;
        return s * (i / s) + ((i - c) % s);
    endfunction

    task automatic build_gold(input int m, input int total);
        int nc;
        nc = ncbps_ref(m);
        for (int k = 0; k < total; k++) begin
            gold[(k / nc) * nc + ref_j(m, k % nc)] = stim[k];
        end
    endtask

    function automatic logic [287:0] gold_vec(input int nc);
        logic [287:0] v;
        v = '0;
        for (int i = 0; i < nc; i++) begin
            v[i] = gold[i];
        end
        return v;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < 384; i++) begin
            stim[i] = 1'b0;
        end
    endtask

    task automatic random_stim(input int total);
        for (int i = 0; i < total; i++) begin
            stim[i] = 1'($urandom);
        end
    endtask

    // Drives stim[0..total-1] one bit per accepted edge; optional random idle cycles and mod noise.
    task automatic send_bits(input logic [1:0] m, input int total, input bit gapped);
        for (int k = 0; k < total; k++) begin
            if (gapped) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge Clk);
                    bus.en  = 1'b0;
                    bus.mod = 2'($urandom);
                end
            end
            @(negedge Clk);
            bus.en      = 1'b1;
            bus.data_in = stim[k];
            bus.mod     = (k == 0 || !gapped) ? m : 2'($urandom);
        end
        @(negedge Clk);
        bus.en      = 1'b0;
        bus.data_in = 1'b0;
    endtask

    // Called right after send_bits: the first sample must already be bit 0 of the symbol.
    task automatic collect(input string tag, input int nc, output logic [287:0] v);
        int vcnt;
        v    = '0;
        vcnt = 0;
        for (int i = 0; i < nc; i++) begin
            @(negedge Clk);
            v[i] = bus.data_out;
            if (bus.out_valid) vcnt++;
            if (i == 0) check_eq({tag, " sym_start"}, 288'(bus.sym_start), 288'(1));
        end
        check_eq({tag, " valid_cycles"}, 288'(vcnt), 288'(nc));
        @(negedge Clk);
        check_eq({tag, " valid_drop"}, 288'(bus.out_valid), 288'(0));
    endtask

    initial begin
        logic [287:0] v;
        logic [287:0] v1;
        logic [287:0] e;
        int vcnt, ss_err, d_err;

        reset       = 1'b1;
        bus.en      = 1'b0;
        bus.mod     = 2'd0;
        bus.data_in = 1'b0;
        repeat (3) @(negedge Clk);
        check_eq("reset out_valid", 288'(bus.out_valid), 288'(0));
        check_eq("reset data_out",  288'(bus.data_out),  288'(0));
        check_eq("reset sym_start", 288'(bus.sym_start), 288'(0));
        reset = 1'b0;
        repeat (2) @(negedge Clk);

        // BPSK, single 1 at k=1 -> n=3
        clear_stim();
        stim[1] = 1'b1;
        send_bits(2'd0, 48, 1'b0);
        collect("bpsk_k1", 48, v);
        e = '0; e[3] = 1'b1;
        check_eq("bpsk_k1 data", v, e);

        // BPSK, single 1 at k=16 -> n=1
        clear_stim();
        stim[16] = 1'b1;
        send_bits(2'd0, 48, 1'b0);
        collect("bpsk_k16", 48, v);
        e = '0; e[1] = 1'b1;
        check_eq("bpsk_k16 data", v, e);

        // 16-QAM, single 1 at k=1 -> n=13
        clear_stim();
        stim[1] = 1'b1;
        send_bits(2'd2, 192, 1'b0);
        collect("qam16_k1", 192, v);
        e = '0; e[13] = 1'b1;
        check_eq("qam16_k1 data", v, e);

        // 64-QAM, 1s at k=1 and k=2 -> n=20 and n=37
        clear_stim();
        stim[1] = 1'b1;
        stim[2] = 1'b1;
        send_bits(2'd3, 288, 1'b0);
        collect("qam64_k12", 288, v);
        e = '0; e[20] = 1'b1; e[37] = 1'b1;
        check_eq("qam64_k12 data", v, e);

        // Four back-to-back QPSK symbols with en held high
        random_stim(384);
        build_gold(1, 384);
        vcnt = 0; ss_err = 0; d_err = 0;
        fork
            send_bits(2'd1, 384, 1'b0);
            begin
                repeat (97) @(negedge Clk);
                for (int i = 0; i < 384; i++) begin
                    @(negedge Clk);
                    if (bus.out_valid) vcnt++;
                    if (bus.sym_start !== ((i % 96) == 0)) ss_err++;
                    if (bus.data_out !== gold[i]) d_err++;
                end
            end
        join
        check_eq("stream valid_cycles", 288'(vcnt), 288'(384));
        check_eq("stream sym_start_errors", 288'(ss_err), 288'(0));
        check_eq("stream data_errors", 288'(d_err), 288'(0));
        @(negedge Clk);
        check_eq("stream valid_drop", 288'(bus.out_valid), 288'(0));

        // 16-QAM random, ungapped then gapped with mod noise after k=0
        random_stim(192);
        build_gold(2, 192);
        send_bits(2'd2, 192, 1'b0);
        collect("qam16_plain", 192, v1);
        check_eq("qam16_plain data", v1, gold_vec(192));
        send_bits(2'd2, 192, 1'b1);
        collect("qam16_gapped", 192, v);
        check_eq("qam16_gapped data", v, gold_vec(192));
        check_eq("qam16_gapped vs plain", v, v1);

        // Reset while bit n=50 of an all-ones QPSK symbol is on the output
        for (int i = 0; i < 96; i++) stim[i] = 1'b1;
        send_bits(2'd1, 96, 1'b0);
        repeat (51) @(negedge Clk);
        check_eq("pre_reset out_valid", 288'(bus.out_valid), 288'(1));
        check_eq("pre_reset data_out",  288'(bus.data_out),  288'(1));
        reset = 1'b1;
        #1;
        check_eq("mid_reset out_valid", 288'(bus.out_valid), 288'(0));
        check_eq("mid_reset data_out",  288'(bus.data_out),  288'(0));
        @(negedge Clk);
        reset = 1'b0;
        repeat (2) @(negedge Clk);
        check_eq("post_reset idle", 288'(bus.out_valid), 288'(0));

        random_stim(48);
        build_gold(0, 48);
        send_bits(2'd0, 48, 1'b0);
        collect("post_reset", 48, v);
        check_eq("post_reset data", v, gold_vec(48));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
